projectile_pool: RTL
====================

Name: projectile_pool

Overview:
- Parametrised multi-slot projectile engine; successor to the single-bullet projectile block.
- Manages NUM_PROJ independent projectiles fired by one shooter.
  - Each projectile travels horizontally in a per-shot direction, one step per frame.
  - Each is retired on screen exit or on hitting the target box.
- Produces the is_proj pixel flag for the color mapper and hit/drop events for stage_control and health logic.
- Sits beside player/npc instances; frame_clk is VGA_VS.

Parameters:
- NUM_PROJ, 4, number of projectile slots (1..16).
- X_STEP, 2, pixels moved per frame tick.
- PROJ_SIZE, 4, projectile half-width/half-height in pixels (square).
- X_MAX, 639, rightmost legal projectile centre X.
- COOLDOWN, 8, frames after a successful spawn during which new shots are refused (0 = none).

Ports:
- Clk, in, 1, system clock (50 MHz).
- Reset_n, in, 1, asynchronous active-low reset.
- Soft_Reset, in, 1, synchronous active-high clear (round restart).
- frame_clk, in, 1, frame strobe (VGA_VS), asynchronous to logic, edge-detected.
- Shoot, in, 1, level fire request (synchronised button).
- Dir, in, 1, 0 = travel right, 1 = travel left; sampled at spawn.
- Shooter_X, in, 10, shooter centre X.
- Shooter_Y, in, 10, shooter centre Y.
- Target_X, in, 10, target centre X.
- Target_Y, in, 10, target centre Y.
- Target_X_Size, in, 10, target half-width.
- Target_Y_Size, in, 10, target half-height.
- DrawX, in, 10, current pixel X.
- DrawY, in, 10, current pixel Y.
- is_proj, out, 1, current pixel lies inside any active projectile (combinational).
- hit, out, 1, one-Clk pulse when at least one projectile hits on a tick.
- drop, out, 1, one-Clk pulse when a pending shot is refused.
- hit_count, out, 8, saturating count of hits.
- active_count, out, $clog2(NUM_PROJ+1), number of active slots.

Behaviour:
- Reset (Reset_n=0, async):
  - All slots inactive, cooldown=0, pending=0.
  - hit=0, drop=0, hit_count=0, active_count=0.
  - Edge-detect registers cleared.
- Soft_Reset=1: same clear on the next Clk edge; it overrides every other event in that cycle.
- frame_clk: two-flop synchroniser, then rising-edge detect gives tick (one Clk wide). Latency from frame_clk rise to tick: 3 Clk.
- Shoot:
  - A rising edge sets pending.
  - pending holds until the next tick; further edges before that tick are merged.
  - Holding Shoot high fires only once.
- Tick processing is a single cycle, in this order:
  1. Move: each active slot does x += X_STEP (Dir=0) or x -= X_STEP (Dir=1), computed in 11-bit signed.
  2. Retire on exit: a moved slot with x > X_MAX or x < 0 becomes inactive, no hit.
  3. Hit test, per still-active moved slot. Hit when both hold (11-bit unsigned, no wrap):
     - |x - Target_X| <= Target_X_Size + PROJ_SIZE
     - |y - Target_Y| <= Target_Y_Size + PROJ_SIZE
     A hitting slot becomes inactive.
  4. hit pulses in the cycle after the tick if any slot hit. hit_count adds the number of slots that hit that tick, saturating at 255.
  5. Spawn, if pending:
     - If cooldown=0 and a slot was free before this tick: take the lowest-index free slot, set x=Shooter_X, y=Shooter_Y, dir=Dir, active, cooldown=COOLDOWN.
     - Otherwise drop pulses.
     - pending clears either way.
     - A slot freed on this same tick is not reusable until the next tick.
     - A newly spawned slot does not move or hit-test until the next tick.
  6. If no spawn occurred and cooldown>0, cooldown decrements.
- y is fixed for the life of a slot.
- active_count is registered and updates together with slot state.
- is_proj = OR over active slots of (|DrawX - x| <= PROJ_SIZE and |DrawY - y| <= PROJ_SIZE). Purely combinational, zero latency.
- Between ticks, slot state is frozen.

Test Plan:
- Reset release, no Shoot, 10 ticks -> active_count=0, is_proj=0 at every DrawX/DrawY, hit_count=0.
- Shoot edge, Shooter=(100,375), Dir=0, target at (600,375) sizes (20,40) -> spawn at next tick, slot0 x=100.
  - After 5 further ticks x=110; is_proj=1 at (110,375), 0 at (115,375).
  - hit pulses on the tick where x reaches 576; hit_count=1, active_count=0.
- Dir=1 shot from x=3, target far right -> after 2 ticks x would be -1, slot retired, no hit, hit_count unchanged.
- COOLDOWN=8, Shoot edges on 6 consecutive ticks, target unreachable -> 1st spawns, next 5 drop. Shoot 9 ticks after 1st spawn -> spawns into slot1.
- NUM_PROJ=4, COOLDOWN=0, 5 shots on consecutive ticks, no exits -> slots 0..3 active, 5th drops, active_count=4. Retire slot1 then shoot -> slot1 reused only on the tick after retirement.
- Two projectiles enter target on same tick -> single hit pulse, hit_count +2. Reset_n low mid-flight -> all outputs 0 immediately.

Source files
------------

// File: rtl/projectile_pool.sv
// ============================================================
// projectile_pool: multi-slot projectile engine with hit/drop events
// Revision: 1.0
// ============================================================
`default_nettype none

module projectile_pool #(
  parameter int NUM_PROJ  = 4,
  parameter int X_STEP    = 2,
  parameter int PROJ_SIZE = 4,
  parameter int X_MAX     = 639,
  parameter int COOLDOWN  = 8
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          Soft_Reset,
  input  logic                          frame_clk,
  input  logic                          Shoot,
  input  logic                          Dir,
  input  logic [9:0]                    Shooter_X,
  input  logic [9:0]                    Shooter_Y,
  input  logic [9:0]                    Target_X,
  input  logic [9:0]                    Target_Y,
  input  logic [9:0]                    Target_X_Size,
  input  logic [9:0]                    Target_Y_Size,
  input  logic [9:0]                    DrawX,
  input  logic [9:0]                    DrawY,
  output logic                          is_proj,
  output logic                          hit,
  output logic                          drop,
  output logic [7:0]                    hit_count,
  output logic [$clog2(NUM_PROJ+1)-1:0] active_count
);

  localparam int ACW = $clog2(NUM_PROJ + 1);
  localparam int CDW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic signed [10:0] X_MAX_S   = 11'(X_MAX);
  localparam logic signed [10:0] STEP_S    = 11'(X_STEP);
  localparam logic [10:0]        PSIZE11   = 11'(PROJ_SIZE);
  localparam logic [9:0]         PSIZE10   = 10'(PROJ_SIZE);
  localparam logic [CDW-1:0]     COOL_INIT = CDW'(COOLDOWN);

  logic [2:0]              sync_q, sync_d;
  logic                    tick_q, tick_d;
  logic                    shoot_q, shoot_d;
  logic                    pending_q, pending_d;
  logic [CDW-1:0]          cool_q, cool_d;
  logic [NUM_PROJ-1:0]     act_q, act_d;
  logic [NUM_PROJ-1:0]     dir_q, dir_d;
  logic signed [10:0]      x_q [NUM_PROJ];
  logic signed [10:0]      x_d [NUM_PROJ];
  logic [9:0]              y_q [NUM_PROJ];
  logic [9:0]              y_d [NUM_PROJ];
  logic                    hit_q, hit_d;
  logic                    drop_q, drop_d;
  logic [7:0]              hit_count_q, hit_count_d;
  logic [ACW-1:0]          active_count_q, active_count_d;

  logic [10:0]        lim_x, lim_y;
  logic signed [10:0] nx;
  logic [10:0]        dx, dy;
  logic [4:0]         hits;
  logic [8:0]         hit_sum;
  logic               spawned;
  logic [9:0]         ddx, ddy;

  assign lim_x = {1'b0, Target_X_Size} + PSIZE11;
  assign lim_y = {1'b0, Target_Y_Size} + PSIZE11;

  always_comb begin
    sync_d         = {sync_q[1:0], frame_clk};
    tick_d         = sync_q[1] & ~sync_q[2];
    shoot_d        = Shoot;
    pending_d      = pending_q;
    cool_d         = cool_q;
    act_d          = act_q;
    dir_d          = dir_q;
    x_d            = x_q;
    y_d            = y_q;
    hit_d          = 1'b0;
    drop_d         = 1'b0;
    hit_count_d    = hit_count_q;
    active_count_d = '0;
    nx             = '0;
    dx             = '0;
    dy             = '0;
    hits           = '0;
    hit_sum        = '0;
    spawned        = 1'b0;

    if (tick_q) begin
      for (int i = 0; i < NUM_PROJ; i++) begin
        if (act_q[i]) begin
          nx     = dir_q[i] ? (x_q[i] - STEP_S) : (x_q[i] + STEP_S);
          x_d[i] = nx;
          if (nx > X_MAX_S || nx < 11'sd0) begin
            act_d[i] = 1'b0;
          end else begin
            dx = ({1'b0, nx[9:0]} >= {1'b0, Target_X}) ? ({1'b0, nx[9:0]} - {1'b0, Target_X})
                                                       : ({1'b0, Target_X} - {1'b0, nx[9:0]});
            dy = ({1'b0, y_q[i]} >= {1'b0, Target_Y}) ? ({1'b0, y_q[i]} - {1'b0, Target_Y})
                                                      : ({1'b0, Target_Y} - {1'b0, y_q[i]});
            if (dx <= lim_x && dy <= lim_y) begin
              act_d[i] = 1'b0;
              hits     = hits + 5'd1;
            end
          end
        end
      end
      hit_d       = (hits != 5'd0);
      hit_sum     = {1'b0, hit_count_q} + {4'b0, hits};
      hit_count_d = hit_sum[8] ? 8'hFF : hit_sum[7:0];

      // Free-slot search looks at pre-tick state so a slot retired now stays empty until next tick
      if (pending_q) begin
        if (cool_q == '0 && !(&act_q)) begin
          for (int i = 0; i < NUM_PROJ; i++) begin
            if (!act_q[i] && !spawned) begin
              spawned  = 1'b1;
              act_d[i] = 1'b1;
              dir_d[i] = Dir;
              x_d[i]   = $signed({1'b0, Shooter_X});
              y_d[i]   = Shooter_Y;
            end
          end
          cool_d = COOL_INIT;
        end else begin
          drop_d = 1'b1;
        end
      end
      if (!spawned && cool_q != '0) begin
        cool_d = cool_q - CDW'(1);
      end
    end

    pending_d = (tick_q ? 1'b0 : pending_q) | (Shoot & ~shoot_q);

    if (Soft_Reset) begin
      sync_d      = '0;
      tick_d      = 1'b0;
      shoot_d     = 1'b0;
      pending_d   = 1'b0;
      cool_d      = '0;
      act_d       = '0;
      dir_d       = '0;
      hit_d       = 1'b0;
      drop_d      = 1'b0;
      hit_count_d = '0;
      for (int i = 0; i < NUM_PROJ; i++) begin
        x_d[i] = '0;
        y_d[i] = '0;
      end
    end

    for (int i = 0; i < NUM_PROJ; i++) begin
      active_count_d = active_count_d + ACW'(act_d[i]);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q         <= '0;
      tick_q         <= 1'b0;
      shoot_q        <= 1'b0;
      pending_q      <= 1'b0;
      cool_q         <= '0;
      act_q          <= '0;
      dir_q          <= '0;
      hit_q          <= 1'b0;
      drop_q         <= 1'b0;
      hit_count_q    <= '0;
      active_count_q <= '0;
      for (int i = 0; i < NUM_PROJ; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      sync_q         <= sync_d;
      tick_q         <= tick_d;
      shoot_q        <= shoot_d;
      pending_q      <= pending_d;
      cool_q         <= cool_d;
      act_q          <= act_d;
      dir_q          <= dir_d;
      hit_q          <= hit_d;
      drop_q         <= drop_d;
      hit_count_q    <= hit_count_d;
      active_count_q <= active_count_d;
      for (int i = 0; i < NUM_PROJ; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
    end
  end

  always_comb begin
    is_proj = 1'b0;
    ddx     = '0;
    ddy     = '0;
    for (int i = 0; i < NUM_PROJ; i++) begin
      ddx = (DrawX >= x_q[i][9:0]) ? (DrawX - x_q[i][9:0]) : (x_q[i][9:0] - DrawX);
      ddy = (DrawY >= y_q[i]) ? (DrawY - y_q[i]) : (y_q[i] - DrawY);
      if (act_q[i] && ddx <= PSIZE10 && ddy <= PSIZE10) begin
        is_proj = 1'b1;
      end
    end
  end

  assign hit          = hit_q;
  assign drop         = drop_q;
  assign hit_count    = hit_count_q;
  assign active_count = active_count_q;

endmodule

`default_nettype wire
